// File: rtl/gfx_sp_vregs_if.sv
// gfx_sp_vregs_if: issue/writeback bundle for the shader vector register file
interface gfx_sp_vregs_if #(
   parameter int LANES    = 4,
   parameter int WORD_W   = 32,
   parameter int REGS     = 8,
   parameter int RD_PORTS = 2
);
   localparam int RW = $clog2(REGS);
   logic                                    ready;
   logic [RD_PORTS-1:0]                     rd_en;
   logic [RD_PORTS-1:0][RW-1:0]             rd_reg;
   logic [RD_PORTS-1:0][LANES-1:0][WORD_W-1:0] rd_data;
   logic                                    wr;
   logic [RW-1:0]                           wr_reg;
   logic [LANES-1:0]                        wr_mask;
   logic [LANES-1:0][WORD_W-1:0]            wr_data;
   modport master (output rd_en, rd_reg, wr, wr_reg, wr_mask, wr_data, input ready, rd_data);
   modport slave  (input rd_en, rd_reg, wr, wr_reg, wr_mask, wr_data, output ready, rd_data);
endinterface

// File: rtl/gfx_sp_vregs.sv
// gfx_sp_vregs: lane-masked vector register file with zeroing sequencer, bypass and registered read ports
module gfx_sp_vregs #(
   parameter int LANES    = 4,
   parameter int WORD_W   = 32,
   parameter int REGS     = 8,
   parameter int RD_PORTS = 2
) (
   input logic          clk,
   input logic          rst_n,
   gfx_sp_vregs_if.slave bus
);
   localparam int RW = $clog2(REGS);
   typedef enum logic {INIT, RUN} state_t;
   state_t                                     state;
   logic [RW-1:0]                              init_idx;
   logic                                       ready_q;
   logic [RD_PORTS-1:0][LANES-1:0][WORD_W-1:0] rd_q;
   logic [RD_PORTS-1:0][LANES-1:0][WORD_W-1:0] byp;
   logic [LANES-1:0][WORD_W-1:0]               mem [REGS];
   assign bus.ready   = ready_q;
   assign bus.rd_data = rd_q;
   // per-port read value with same-cycle write forwarded lane by lane
   always_comb begin
      byp = '0;
      for (int p = 0; p < RD_PORTS; p++)
         for (int i = 0; i < LANES; i++)
            byp[p][i] = (bus.wr && bus.wr_mask[i] && bus.wr_reg == bus.rd_reg[p]) ? bus.wr_data[i] : mem[bus.rd_reg[p]][i];
   end
   // storage: zeroed one register per cycle in INIT, lane-masked writes in RUN
   always_ff @(posedge clk)
      if (state == INIT)
         mem[init_idx] <= '0;
      else if (bus.wr)
         for (int i = 0; i < LANES; i++)
            if (bus.wr_mask[i]) mem[bus.wr_reg][i] <= bus.wr_data[i];
   // sequencer and registered read ports
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= INIT;
         init_idx <= '0;
         ready_q  <= 1'b0;
         rd_q     <= '0;
      end else if (state == INIT) begin
         init_idx <= init_idx + 1'b1;
         if (&init_idx) begin
            state   <= RUN;
            ready_q <= 1'b1;
         end
      end else
         for (int p = 0; p < RD_PORTS; p++)
            if (bus.rd_en[p]) rd_q[p] <= byp[p];
endmodule

// File: tb/tb_gfx_sp_vregs.sv
// tb_gfx_sp_vregs: directed checks on the default configuration plus a modelled run on a wide configuration
module tb_gfx_sp_vregs;
   logic clk = 1'b0;
   logic rst_n_a = 1'b0;
   logic rst_n_b = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [127:0] exp_a;
   logic [7:0][15:0] gm [16];
   logic [2:0][7:0][15:0] expb;
   localparam logic [127:0] ZERO = '0;
   localparam logic [127:0] A5M  = 128'hA5A5A5A5_00000000_A5A5A5A5_00000000;
   localparam logic [127:0] BYP  = 128'h00001111_00001111_00002222_00002222;
   localparam logic [127:0] R77  = {4{32'h77}};
   always #5 clk = ~clk;
   gfx_sp_vregs_if #(.LANES(4), .WORD_W(32), .REGS(8), .RD_PORTS(2)) bus_a ();
   gfx_sp_vregs_if #(.LANES(8), .WORD_W(16), .REGS(16), .RD_PORTS(3)) bus_b ();
   gfx_sp_vregs #(.LANES(4), .WORD_W(32), .REGS(8), .RD_PORTS(2)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave));
   gfx_sp_vregs #(.LANES(8), .WORD_W(16), .REGS(16), .RD_PORTS(3)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave));
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus_a.wr = 1'b1;
      bus_a.wr_reg = '0;
      bus_a.wr_mask = '1;
      bus_a.wr_data = {4{32'hDEADBEEF}};
      bus_a.rd_en = '1;
      bus_a.rd_reg = '0;
      bus_b.wr = 1'b0;
      bus_b.wr_reg = '0;
      bus_b.wr_mask = '0;
      bus_b.wr_data = '0;
      bus_b.rd_en = '0;
      bus_b.rd_reg = '0;
      repeat (2) tick;
      check("a_rst_ready", {127'b0, bus_a.ready}, ZERO);
      check("a_rst_rd0", bus_a.rd_data[0], ZERO);
      check("a_rst_rd1", bus_a.rd_data[1], ZERO);
      rst_n_a = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         bus_a.wr_reg = 3'(e + 6);
         bus_a.rd_reg[0] = 3'(e);
         bus_a.rd_reg[1] = 3'(e + 3);
         tick;
         check("a_init_ready", {127'b0, bus_a.ready}, {127'b0, e == 8});
         check("a_init_rd0", bus_a.rd_data[0], ZERO);
      end
      bus_a.wr = 1'b0;
      for (int r = 0; r < 8; r++) begin
         bus_a.rd_reg[0] = 3'(r);
         bus_a.rd_reg[1] = 3'(7 - r);
         tick;
         check("a_zero_rd0", bus_a.rd_data[0], ZERO);
         check("a_zero_rd1", bus_a.rd_data[1], ZERO);
      end
      bus_a.wr = 1'b1;
      bus_a.wr_reg = 3'd3;
      bus_a.wr_data = {4{32'hA5A5A5A5}};
      bus_a.wr_mask = 4'b1111;
      bus_a.rd_reg = '0;
      tick;
      bus_a.wr_data = '0;
      bus_a.wr_mask = 4'b0101;
      tick;
      bus_a.wr = 1'b0;
      bus_a.rd_reg[0] = 3'd3;
      check("a_mask_latency", bus_a.rd_data[0], ZERO);
      tick;
      check("a_mask_rd", bus_a.rd_data[0], A5M);
      bus_a.wr = 1'b1;
      bus_a.wr_mask = 4'b0000;
      bus_a.wr_data = '1;
      tick;
      check("a_nomask_byp", bus_a.rd_data[0], A5M);
      bus_a.wr = 1'b0;
      tick;
      check("a_nomask_rd", bus_a.rd_data[0], A5M);
      bus_a.wr = 1'b1;
      bus_a.wr_reg = 3'd5;
      bus_a.wr_data = {4{32'h1111}};
      bus_a.wr_mask = 4'b1111;
      tick;
      bus_a.wr_data = {4{32'h2222}};
      bus_a.wr_mask = 4'b0011;
      bus_a.rd_reg[0] = 3'd5;
      bus_a.rd_reg[1] = 3'd5;
      tick;
      check("a_byp_rd0", bus_a.rd_data[0], BYP);
      check("a_byp_rd1", bus_a.rd_data[1], BYP);
      bus_a.wr = 1'b0;
      tick;
      check("a_byp_after", bus_a.rd_data[0], BYP);
      bus_a.wr = 1'b1;
      bus_a.wr_reg = 3'd2;
      bus_a.wr_data = R77;
      bus_a.wr_mask = 4'b1111;
      tick;
      bus_a.wr = 1'b0;
      bus_a.rd_reg[0] = 3'd3;
      bus_a.rd_reg[1] = 3'd2;
      tick;
      check("a_hold_rd1", bus_a.rd_data[1], R77);
      check("a_hold_rd0", bus_a.rd_data[0], A5M);
      bus_a.rd_en = 2'b01;
      bus_a.rd_reg[1] = 3'd4;
      for (int k = 0; k < 3; k++) begin
         bus_a.rd_reg[0] = (k == 0) ? 3'd5 : (k == 1) ? 3'd2 : 3'd3;
         exp_a = (k == 0) ? BYP : (k == 1) ? R77 : A5M;
         tick;
         check("a_hold_keep1", bus_a.rd_data[1], R77);
         check("a_hold_upd0", bus_a.rd_data[0], exp_a);
      end
      bus_a.rd_en = '1;
      bus_a.wr = 1'b1;
      bus_a.wr_mask = 4'b1111;
      for (int r = 0; r < 8; r++) begin
         bus_a.wr_reg = 3'(r);
         for (int i = 0; i < 4; i++) bus_a.wr_data[i] = 32'((r << 8) + i + 1);
         tick;
      end
      bus_a.wr = 1'b0;
      bus_a.rd_reg[0] = 3'd7;
      bus_a.rd_reg[1] = 3'd1;
      tick;
      check("a_fill_rd0", bus_a.rd_data[0], 128'h00000704_00000703_00000702_00000701);
      check("a_fill_rd1", bus_a.rd_data[1], 128'h00000104_00000103_00000102_00000101);
      rst_n_a = 1'b0;
      #1;
      check("a_mid_ready", {127'b0, bus_a.ready}, ZERO);
      check("a_mid_rd0", bus_a.rd_data[0], ZERO);
      check("a_mid_rd1", bus_a.rd_data[1], ZERO);
      tick;
      rst_n_a = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick;
         check("a_reinit_ready", {127'b0, bus_a.ready}, {127'b0, e == 8});
      end
      for (int r = 0; r < 8; r++) begin
         bus_a.rd_reg[0] = 3'(r);
         bus_a.rd_reg[1] = 3'(7 - r);
         tick;
         check("a_rezero_rd0", bus_a.rd_data[0], ZERO);
         check("a_rezero_rd1", bus_a.rd_data[1], ZERO);
      end
      rst_n_b = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick;
         check("b_init_ready", {127'b0, bus_b.ready}, {127'b0, e == 16});
      end
      for (int r = 0; r < 16; r++) gm[r] = '0;
      expb = '0;
      for (int n = 0; n < 400; n++) begin
         bus_b.wr = 1'($urandom);
         bus_b.wr_reg = 4'($urandom);
         bus_b.wr_mask = 8'($urandom);
         for (int i = 0; i < 8; i++) bus_b.wr_data[i] = 16'($urandom);
         bus_b.rd_en = 3'($urandom);
         for (int p = 0; p < 3; p++)
            bus_b.rd_reg[p] = ($urandom_range(0, 2) == 0) ? bus_b.wr_reg : 4'($urandom);
         for (int p = 0; p < 3; p++)
            if (bus_b.rd_en[p])
               for (int i = 0; i < 8; i++)
                  expb[p][i] = (bus_b.wr && bus_b.wr_mask[i] && bus_b.rd_reg[p] == bus_b.wr_reg) ? bus_b.wr_data[i] : gm[bus_b.rd_reg[p]][i];
         if (bus_b.wr)
            for (int i = 0; i < 8; i++)
               if (bus_b.wr_mask[i]) gm[bus_b.wr_reg][i] = bus_b.wr_data[i];
         tick;
         for (int p = 0; p < 3; p++) check($sformatf("b_rand_p%0d_n%0d", p, n), bus_b.rd_data[p], expb[p]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gfx_sp_vregs.md
# gfx_sp_vregs

Parametrised vector register file for the shader processor: `REGS` registers, each `LANES` lanes of `WORD_W` bits, with `RD_PORTS` independent registered read ports and one lane-masked write port. It replaces the fixed two-port, unregistered lane file. It adds four things that file lacks: a post-reset zeroing sequencer, per-lane write masking, write-to-read bypass, and per-port read enables. It sits between the SP decode/issue stage (read addresses) and the SP writeback stage (write port).

## Interface
Parameters:
- `LANES`, 4, vector lanes per register
- `WORD_W`, 32, bits per lane
- `REGS`, 8, register count; power of two, ≥2; `RW = $clog2(REGS)`
- `RD_PORTS`, 2, read ports, ≥1

Ports:
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `ready`  out  1  high once zeroing sequence is complete
- `rd_en`  in  [RD_PORTS]  per-port read enable
- `rd_reg`  in  [RD_PORTS][RW]  per-port read address
- `rd_data`  out  [RD_PORTS][LANES][WORD_W]  registered read data
- `wr`  in  1  write strobe
- `wr_reg`  in  RW  write address
- `wr_mask`  in  LANES  per-lane write enable
- `wr_data`  in  [LANES][WORD_W]  write data

## Operation
- FSM states: INIT, RUN.
  - `rst_n` low (async): state=INIT, counter `init_idx`=0, `ready`=0, all `rd_data`=0.
  - Array contents are not reset asynchronously.
- INIT: each clock edge writes all lanes of register `init_idx` to 0, then increments `init_idx`.
  - The edge that writes `REGS-1` moves the FSM to RUN and sets `ready`=1.
  - While in INIT: `wr` is ignored; `rd_en` is ignored; `rd_data` holds 0.
- RUN: `ready` stays 1 until the next reset.
- Write (RUN, `wr`=1): on the edge, lane i of `wr_reg` takes `wr_data[i]` only where `wr_mask[i]`=1; other lanes keep their value.
  - `wr`=1 with `wr_mask`=0 is a no-op.
- Read (RUN, `rd_en[p]`=1): on the edge, `rd_data[p]` loads register `rd_reg[p]`.
  - `rd_en[p]`=0: `rd_data[p]` holds its previous value.
- Bypass: when a port reads in the same cycle as a write to the same register, the read returns per lane:
  - `wr_data[i]` where `wr_mask[i]`=1;
  - the old contents where `wr_mask[i]`=0.
  - This applies to every port independently; all ports may address the same register.
- Ports are fully independent; any combination of addresses is legal.
- Reset asserted mid-operation (INIT or RUN): immediate return to INIT with `init_idx`=0. The full zeroing sequence reruns after release.

## Timing
- Reset release: `ready` rises after the `REGS`-th rising edge with `rst_n` high. The first accepted write/read is on edge `REGS+1`.
- Read latency: 1 cycle. Address presented in cycle N appears on `rd_data` in cycle N+1.
- Write latency: 1 cycle.
  - A write in cycle N is visible to a non-bypassed read issued in cycle N+1, i.e. data out in N+2.
  - Via bypass, a same-cycle read sees it in N+1.
- No back-pressure; one write and `RD_PORTS` reads per cycle, every cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, `REGS`=8: release `rst_n`, hold `wr`=1 and `rd_en`=all-ones throughout → `ready`=0 for 8 edges, then 1. Writes during INIT do not land. Reading r0..r7 afterwards returns all zeros.
- Masked write: write r3 with `wr_data`={4{32'hA5A5A5A5}}, mask 4'b1111. Next cycle write r3 with {4{32'h0}}, mask 4'b0101. Read r3 → lanes {0,2}=0 and lanes {1,3}=32'hA5A5A5A5, data one cycle after the address.
- Bypass: r5 holds {4{32'h1111}}. In one cycle, write r5 with {4{32'h2222}} mask 4'b0011 while port0 and port1 both read r5 → both ports show lanes 0,1=32'h2222 and lanes 2,3=32'h1111 next cycle.
- Read enable hold: port1 reads r2 (32'h77 in all lanes). Then set `rd_en[1]`=0 and change `rd_reg[1]` to r4 for 3 cycles → `rd_data[1]` stays 32'h77 while port0 updates normally.
- Reset mid-run: fill r0..r7 with nonzero data, assert `rst_n` low for 1 cycle mid-stream → `ready` and `rd_data` drop to 0 immediately. After release, `ready` returns after 8 edges and every register reads 0.
- Randomised parametrisation: `LANES`=8, `WORD_W`=16, `REGS`=16, `RD_PORTS`=3, with random reads, writes and masks → results match a golden model including bypass.
